// File: rtl/mdu_sequencer.sv
// Multiply/divide unit for the E stage: HI/LO registers plus a fixed-latency busy sequencer.
// Optional build macro MDU_DIVZERO_GUARD_EN shortens divide-by-zero to one busy cycle with no HI/LO write.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_d,
  output logic        start,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

`ifdef MDU_DIVZERO_GUARD_EN
  localparam bit DIVZERO_GUARD = 1'b1;
`else
  localparam bit DIVZERO_GUARD = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          busy_r;
  logic [31:0]   a_r, b_r, hi_r, lo_r;
  logic          sgn_r, wr_r;
  logic          start_s, is_mul_s, is_sgn_s, div0_s, done_s;
  logic [31:0]   a_mag_s, b_mag_s, q_mag_s, r_mag_s, q_s, r_s;
  logic [63:0]   prod_mag_s, prod_s, res_s;
  logic          neg_s;

  // Decode the E-stage opcode into multiply/signed flags
  always_comb begin
    is_mul_s = 1'b0;
    is_sgn_s = 1'b0;
    case (md_op)
      3'd1: begin is_mul_s = 1'b1; is_sgn_s = 1'b1; end
      3'd2: begin is_mul_s = 1'b1; is_sgn_s = 1'b0; end
      3'd3: begin is_mul_s = 1'b0; is_sgn_s = 1'b1; end
      3'd4: begin is_mul_s = 1'b0; is_sgn_s = 1'b0; end
      default: begin is_mul_s = 1'b0; is_sgn_s = 1'b0; end
    endcase
  end

  // Handshake outputs: start only when idle, stall covers start cycle and every busy cycle
  always_comb begin
    start_s   = (md_op >= 3'd1) && (md_op <= 3'd4) && (state_r == S_IDLE);
    div0_s    = !is_mul_s && (rt_val == 32'd0);
    done_s    = (state_r != S_IDLE) && (cnt_r == CW'(1));
    stall_req = md_use_d & (start_s | busy_r);
  end

  // Next-state and counter sequencing
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (start_s) begin
          if (is_mul_s) begin
            state_nxt_s = S_MUL;
            cnt_nxt_s   = CW'(MULT_CYCLES);
          end else if (DIVZERO_GUARD && div0_s) begin
            state_nxt_s = S_DIV;
            cnt_nxt_s   = CW'(1);
          end else begin
            state_nxt_s = S_DIV;
            cnt_nxt_s   = CW'(DIV_CYCLES);
          end
        end else begin
          state_nxt_s = S_IDLE;
          cnt_nxt_s   = cnt_r;
        end
      end
      S_MUL, S_DIV: begin
        if (cnt_r == CW'(1)) begin
          state_nxt_s = S_IDLE;
          cnt_nxt_s   = CW'(0);
        end else begin
          state_nxt_s = state_r;
          cnt_nxt_s   = cnt_r - CW'(1);
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = CW'(0);
      end
    endcase
  end

  // State, counter and busy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= CW'(0);
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (state_nxt_s != S_IDLE);
    end
  end

  // Sign-magnitude arithmetic shared by the signed and unsigned multiply/divide paths
  always_comb begin
    a_mag_s    = (sgn_r && a_r[31]) ? (32'd0 - a_r) : a_r;
    b_mag_s    = (sgn_r && b_r[31]) ? (32'd0 - b_r) : b_r;
    neg_s      = sgn_r & (a_r[31] ^ b_r[31]);
    prod_mag_s = {32'd0, a_mag_s} * {32'd0, b_mag_s};
    prod_s     = neg_s ? (64'd0 - prod_mag_s) : prod_mag_s;
    q_mag_s    = a_mag_s / b_mag_s;
    r_mag_s    = a_mag_s % b_mag_s;
    q_s        = neg_s ? (32'd0 - q_mag_s) : q_mag_s;
    r_s        = (sgn_r && a_r[31]) ? (32'd0 - r_mag_s) : r_mag_s;
    if (state_r == S_MUL) begin
      res_s = prod_s;
    end else if (b_r == 32'd0) begin
      res_s = {a_r, 32'hFFFF_FFFF};
    end else begin
      res_s = {r_s, q_s};
    end
  end

  // Operand capture and HI/LO update (result write or mthi/mtlo when idle)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r   <= 32'd0;
      b_r   <= 32'd0;
      sgn_r <= 1'b0;
      wr_r  <= 1'b0;
      hi_r  <= 32'd0;
      lo_r  <= 32'd0;
    end else begin
      if (start_s) begin
        a_r   <= rs_val;
        b_r   <= rt_val;
        sgn_r <= is_sgn_s;
        wr_r  <= !(DIVZERO_GUARD && div0_s);
      end
      if (done_s && wr_r) begin
        hi_r <= res_s[63:32];
        lo_r <= res_s[31:0];
      end else if (state_r == S_IDLE) begin
        case (md_op)
          3'd5:    hi_r <= rs_val;
          3'd6:    lo_r <= rs_val;
          default: begin hi_r <= hi_r; lo_r <= lo_r; end
        endcase
      end
    end
  end

  assign start = start_s;
  assign busy  = busy_r;
  assign hi    = hi_r;
  assign lo    = lo_r;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: randomized ops checked against an arithmetic reference model.
module tb_mdu_sequencer;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        md_use_d = 1'b0;
  logic        start, busy, stall_req;
  logic [31:0] hi, lo;

  mdu_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .rs_val(rs_val), .rt_val(rt_val),
    .md_use_d(md_use_d), .start(start), .busy(busy), .stall_req(stall_req),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] phi;
    logic [31:0] plo;
    logic [31:0] nhi;
    logic [31:0] nlo;
    int          cycles;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          bcnt = 0;
  logic        pb = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] phi, input logic [31:0] plo);
    exp_t        e;
    longint      sa, sb, t;
    logic [63:0] p;
    e.phi = phi; e.plo = plo; e.nhi = phi; e.nlo = plo; e.cycles = 0;
    if (op == 3'd1 || op == 3'd2) begin
      if (op == 3'd1) begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
      end else begin
        sa = longint'(a); sb = longint'(b);
      end
      t = sa * sb;
      p = t;
      e.nhi = p[63:32]; e.nlo = p[31:0]; e.cycles = MC;
    end else if (b == 32'd0) begin
`ifdef MDU_DIVZERO_GUARD_EN
      e.cycles = 1;
`else
      e.nhi = a; e.nlo = 32'hFFFF_FFFF; e.cycles = DC;
`endif
    end else begin
      if (op == 3'd3) begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
      end else begin
        sa = longint'(a); sb = longint'(b);
      end
      t = sa / sb; e.nlo = t[31:0];
      t = sa % sb; e.nhi = t[31:0];
      e.cycles = DC;
    end
    return e;
  endfunction

  // Monitor: HI/LO must hold during busy; on busy fall pop and compare result and latency
  always @(negedge clk) begin
    if (reset) begin
      pb   = 1'b0;
      bcnt = 0;
    end else begin
      if (busy === 1'b1) begin
        bcnt++;
        if (q.size() > 0) begin
          chk("hold_hi", 64'(hi), 64'(q[0].phi));
          chk("hold_lo", 64'(lo), 64'(q[0].plo));
        end
      end else if (pb) begin
        if (q.size() == 0) begin
          chk("unexpected_busy_fall", 64'(1), 64'(0));
        end else begin
          mon_e = q.pop_front();
          chk("res_hi", 64'(hi), 64'(mon_e.nhi));
          chk("res_lo", 64'(lo), 64'(mon_e.nlo));
          chk("busy_cycles", 64'(bcnt), 64'(mon_e.cycles));
        end
        bcnt = 0;
      end
      pb = busy;
    end
  end

  // Issue one op at the current negedge; returns just after the negedge where the DUT is idle again
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d);
    exp_t e;
    int   sc;
    int   guard;
    bit   arith;
    arith = (op >= 3'd1) && (op <= 3'd4);
    md_op = op; rs_val = a; rt_val = b; md_use_d = use_d;
    #1;
    chk("start", 64'(start), 64'(arith));
    chk("stall_start", 64'(stall_req), 64'(use_d & arith));
    sc = int'(stall_req);
    e = model(op, a, b, m_hi, m_lo);
    if (arith) begin
      q.push_back(e);
      m_hi = e.nhi; m_lo = e.nlo;
    end else if (op == 3'd5) begin
      m_hi = a;
    end else if (op == 3'd6) begin
      m_lo = a;
    end
    @(negedge clk);
    md_op = 3'd0; rs_val = $urandom; rt_val = $urandom;
    if (arith) begin
      guard = 0;
      while (busy === 1'b1 && guard < 100) begin
        sc += int'(stall_req);
        md_op = 3'($urandom_range(0, 7));
        #1;
        chk("start_while_busy", 64'(start), 64'(0));
        @(negedge clk);
        guard++;
      end
      md_op = 3'd0;
      #1;
      chk("busy_timeout", 64'(guard < 100), 64'(1));
      chk("stall_cycles", 64'(sc), 64'(use_d ? e.cycles + 1 : 0));
      chk("stall_after", 64'(stall_req), 64'(0));
    end else begin
      #1;
      chk("mt_hi", 64'(hi), 64'(m_hi));
      chk("mt_lo", 64'(lo), 64'(m_lo));
      chk("mt_busy", 64'(busy), 64'(0));
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'($urandom_range(0, 9));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    md_use_d = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_stall", 64'(stall_req), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    run_op(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(3'd4, 32'd7, 32'd2, 1'b0);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd5, 32'h0000_1234, 32'd0, 1'b0);
    run_op(3'd6, 32'hABCD_0000, 32'd0, 1'b0);
    run_op(3'd3, 32'h0000_0055, 32'd0, 1'b1);
    run_op(3'd4, 32'h1234_5678, 32'd0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
    end

    // Reset in busy cycle 4 of a divide: everything clears at once and nothing is written later
    md_op = 3'd3; rs_val = 32'd100; rt_val = 32'd7; md_use_d = 1'b0;
    @(negedge clk);
    md_op = 3'd0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_hi", 64'(hi), 64'(0));
    chk("mid_rst_lo", 64'(lo), 64'(0));
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("post_rst_busy", 64'(busy), 64'(0));
    end
    chk("post_rst_hi", 64'(hi), 64'(0));
    chk("post_rst_lo", 64'(lo), 64'(0));
    chk("queue_drained", 64'(q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
